bu_ntt: RTL
===========

// Module: bu_ntt
// PURPOSE
//   Pipelined forward-NTT (Cooley-Tukey) butterfly for the ML-KEM NTT datapath, modulus q = 3329.
//   Computes t = W*B mod q, A' = A + t mod q, B' = A - t mod q, one butterfly per cycle.
//   It is the forward counterpart of the team's inverse (Gentleman-Sande) butterfly.
//   Sits between the NTT address generator / coefficient RAM read port and the RAM write-back path.
// PARAMETERS
//   WIDTH  16    coefficient / twiddle width in bits
//   Q      3329  modulus; all operands and results lie in [0, Q-1]
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   en         in   1      pipeline advance; 0 freezes every pipeline and output register
//   in_valid   in   1      A_In/B_In/W_In carry a butterfly this cycle (sampled only when en=1)
//   A_In       in   WIDTH  top coefficient, 0..Q-1
//   B_In       in   WIDTH  bottom coefficient, 0..Q-1
//   W_In       in   WIDTH  twiddle factor (zeta), 0..Q-1
//   out_valid  out  1      A_Out/B_Out hold a finished butterfly
//   A_Out      out  WIDTH  (A + W*B) mod Q
//   B_Out      out  WIDTH  (A - W*B) mod Q
//   mode       in   1      present only with BU_NTT_INTT_EN; 0 = forward, 1 = inverse
// BEHAVIOUR
//   - Reset: rst=1 at a rising edge clears all pipeline data, valid bits, out_valid, A_Out and B_Out to 0.
//     rst takes priority over en.
//   - Latency: exactly 8 en=1 cycles from an accepted input (in_valid=1, en=1) to out_valid=1 with its result.
//     Throughput is 1 per cycle; no bubbles are inserted.
//   - Valid: a 1-bit valid travels alongside the data through every stage. out_valid is registered.
//     in_valid=0 cycles produce out_valid=0 slots in order.
//   - Stall: while en=0, all registers hold, including out_valid/A_Out/B_Out. Inputs are ignored.
//     Resuming en=1 continues exactly where the pipeline stopped, with no loss or duplication.
//   - Data path:
//       - A_In is delay-matched to t.
//       - Product W*B is 32-bit unsigned; Barrett reduction gives t in [0, Q-1].
//       - Sum: A+t is 17 bits; subtract Q if >= Q.
//       - Difference: A-t, with Q added if negative.
//       - Both results are registered before output.
//   - Out-of-range inputs (>= Q) are illegal. The results are then unspecified, but valid timing is unchanged.
//   - Reset mid-operation: every in-flight butterfly is discarded. out_valid is 0 on the cycle after reset.
//   - Simultaneous rst=1 and in_valid=1: the input is dropped.
//   - Boundaries: W=0 gives A'=B'=A. B=0 gives A'=B'=A. A=0,t=0 gives 0,0. A+t=Q wraps to 0.
// CONFIGURATION
//   BU_NTT_INTT_EN defined:
//     - adds the mode port, sampled with in_valid and carried down the pipeline per butterfly.
//     - mode=1 computes A' = (A+B) mod Q and B' = (((B-A) mod Q) * W) mod Q, same 8-cycle latency.
//     - forward and inverse butterflies may interleave cycle by cycle.
//   BU_NTT_INTT_EN undefined:
//     - no mode port; forward only.
// TESTING
//   1. A=5, B=7, W=1 -> after 8 cycles out_valid=1, A_Out=12, B_Out=3327.
//   2. A=0, B=3328, W=3328 -> A_Out=1, B_Out=3328. A=3328, B=1, W=1 -> A_Out=0, B_Out=3327.
//   3. 256 back-to-back random legal vectors -> results match the golden model in order, out_valid high for 256 cycles.
//   4. en=0 for 5 cycles mid-stream -> outputs frozen, then the sequence resumes with no loss or duplication.
//   5. rst pulse with 4 butterflies in flight -> outputs 0, out_valid 0, none of the 4 appear later.
//   6. [BU_NTT_INTT_EN] mode=1, A=5, B=7, W=2 -> A_Out=12, B_Out=4. Alternating mode each cycle -> each result correct.

Source files
------------

// File: rtl/bu_ntt.sv
// bu_ntt: 8-stage forward NTT butterfly mod Q with Barrett reduction.
// Define BU_NTT_INTT_EN to add a per-butterfly mode port for inverse (Gentleman-Sande) butterflies.
module bu_ntt #(
    parameter int WIDTH = 16,
    parameter int Q     = 3329
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
    input  logic [WIDTH-1:0] W_In,
`ifdef BU_NTT_INTT_EN
    input  logic             mode,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] A_Out,
    output logic [WIDTH-1:0] B_Out
);
    localparam int K = 24;
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
    localparam logic [WIDTH:0]   QX = (WIDTH+1)'(Q);
    localparam logic [WIDTH-1:0] MU = WIDTH'((2**K) / Q);
    logic             mode_in;
    logic [7:1]       v_d;
    logic [6:1]       m_d;
    logic [WIDTH-1:0] a_d [1:6];
    logic [WIDTH-1:0] s_d [2:6];
    logic [WIDTH-1:0] b1, w1, x2, w2, qe4, r5, t6, a7, b7;
    logic [2*WIDTH-1:0] p3, p4, qq;
    logic [3*WIDTH-1:0] pm;
    logic [WIDTH:0]   s_full, sum_full;
    logic [WIDTH-1:0] x_c, s_c, ao_c, bo_c;
`ifdef BU_NTT_INTT_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif
    // Inverse mode multiplies (B-A) by the twiddle; forward multiplies B directly.
    always_comb begin
        x_c      = m_d[1] ? (b1 >= a_d[1] ? b1 - a_d[1] : b1 + QW - a_d[1]) : b1;
        s_full   = {1'b0, a_d[1]} + {1'b0, b1};
        s_c      = s_full >= QX ? WIDTH'(s_full - QX) : s_full[WIDTH-1:0];
        pm       = {{WIDTH{1'b0}}, p3} * {{2*WIDTH{1'b0}}, MU};
        qq       = {{WIDTH{1'b0}}, qe4} * {{WIDTH{1'b0}}, QW};
        sum_full = {1'b0, a_d[6]} + {1'b0, t6};
        ao_c     = m_d[6] ? s_d[6] : (sum_full >= QX ? WIDTH'(sum_full - QX) : sum_full[WIDTH-1:0]);
        bo_c     = m_d[6] ? t6 : (a_d[6] >= t6 ? a_d[6] - t6 : a_d[6] + QW - t6);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_d       <= '0;
            m_d       <= '0;
            for (int i = 1; i <= 6; i++) a_d[i] <= '0;
            for (int i = 2; i <= 6; i++) s_d[i] <= '0;
            b1        <= '0;
            w1        <= '0;
            x2        <= '0;
            w2        <= '0;
            p3        <= '0;
            p4        <= '0;
            qe4       <= '0;
            r5        <= '0;
            t6        <= '0;
            a7        <= '0;
            b7        <= '0;
            out_valid <= 1'b0;
            A_Out     <= '0;
            B_Out     <= '0;
        end else if (en) begin
            v_d       <= {v_d[6:1], in_valid};
            m_d       <= {m_d[5:1], mode_in};
            a_d[1]    <= A_In;
            for (int i = 2; i <= 6; i++) a_d[i] <= a_d[i-1];
            s_d[2]    <= s_c;
            for (int i = 3; i <= 6; i++) s_d[i] <= s_d[i-1];
            b1        <= B_In;
            w1        <= W_In;
            x2        <= x_c;
            w2        <= w1;
            p3        <= {{WIDTH{1'b0}}, x2} * {{WIDTH{1'b0}}, w2};
            p4        <= p3;
            // Barrett quotient estimate is at most one short, so a single subtract of Q finishes it.
            qe4       <= pm[K+WIDTH-1:K];
            r5        <= WIDTH'(p4 - qq);
            t6        <= r5 >= QW ? r5 - QW : r5;
            a7        <= ao_c;
            b7        <= bo_c;
            out_valid <= v_d[7];
            A_Out     <= a7;
            B_Out     <= b7;
        end
    end
endmodule
